// File: rtl/split_4_ctrl.sv
// rtl/split_4_ctrl.sv - one-to-four packet router with forward/backward latency and per-output credits.
// A single packet is in flight at a time: it is captured, delayed, offered on its output, then held off by a backward delay.
module split_4_ctrl #(
  parameter int WIDTH   = 11,
  parameter int SEL_LSB = 0,
  parameter int FL      = 1,
  parameter int BL      = 1,
  parameter int CREDITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [3:0]       credit_ret,
  output logic             busy,
  output logic [15:0]      pkt_count,
  output logic             cred_err
);

  typedef enum logic [1:0] {IDLE, FWD, SEND, BACK} state_t;

  localparam logic [3:0] FL_CNT   = (FL > 0) ? 4'(FL - 1) : 4'd0;
  localparam logic [3:0] BL_CNT   = (BL > 0) ? 4'(BL - 1) : 4'd0;
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       credit_q [4];
  logic [15:0]      pkt_count_q;
  logic [15:0]      pkt_count_d;
  logic             cred_err_q;

  logic             accept;
  logic [3:0]       fire_vec;
  logic             fire;

  // The offer is gated by the selected output's credit, so a fire can never underflow it.
  always_comb begin
    out_valid = 4'b0000;
    if (state_q == SEND && credit_q[sel_q] != 3'd0) begin
      out_valid[sel_q] = 1'b1;
    end
  end

  assign fire_vec    = out_valid & out_ready;
  assign fire        = |fire_vec;
  assign accept      = in_valid && (state_q == IDLE);
  assign pkt_count_d = pkt_count_q + {15'd0, fire};

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign pkt_count = pkt_count_q;
  assign cred_err  = cred_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sel_q       <= 2'd0;
      data_q      <= '0;
      pkt_count_q <= 16'd0;
      cred_err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        credit_q[i] <= CRED_MAX;
      end
    end else begin
      pkt_count_q <= pkt_count_d;

      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q <= in_data;
            sel_q  <= in_data[SEL_LSB+1:SEL_LSB];
            cnt_q  <= FL_CNT;
            state_q <= (FL > 0) ? FWD : SEND;
          end
        end
        FWD: begin
          if (cnt_q == 4'd0) state_q <= SEND;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        SEND: begin
          if (fire) begin
            cnt_q   <= BL_CNT;
            state_q <= (BL > 0) ? BACK : IDLE;
          end
        end
        BACK: begin
          if (cnt_q == 4'd0) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase

      // A fire and a return on the same output cancel; a return into a full counter is an error.
      for (int i = 0; i < 4; i++) begin
        case ({fire_vec[i], credit_ret[i]})
          2'b10: credit_q[i] <= credit_q[i] - 3'd1;
          2'b01: begin
            if (credit_q[i] == CRED_MAX) cred_err_q  <= 1'b1;
            else                         credit_q[i] <= credit_q[i] + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_split_4_ctrl.sv
// tb/tb_split_4_ctrl.sv - directed checks of split_4_ctrl with default and zero-latency instances.
module tb_split_4_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, busy, cred_err;
  logic [10:0] in_data, out_data;
  logic [3:0]  out_valid, out_ready, credit_ret;
  logic [15:0] pkt_count;

  logic        z_in_valid, z_in_ready, z_busy, z_cred_err;
  logic [10:0] z_in_data, z_out_data;
  logic [3:0]  z_out_valid, z_out_ready, z_credit_ret;
  logic [15:0] z_pkt_count;

  int n_run  = 0;
  int n_fail = 0;

  split_4_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .credit_ret(credit_ret),
    .busy(busy), .pkt_count(pkt_count), .cred_err(cred_err)
  );

  split_4_ctrl #(.FL(0), .BL(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data), .credit_ret(z_credit_ret),
    .busy(z_busy), .pkt_count(z_pkt_count), .cred_err(z_cred_err)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  // Stimulus only: one packet through the default instance with all outputs ready.
  task automatic send_pkt(input logic [10:0] d);
    in_valid = 1'b1; in_data = d; cyc();
    in_valid = 1'b0; cyc(); cyc(); cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 4'hF; credit_ret = 4'h0;
    z_in_valid = 1'b0; z_in_data = '0; z_out_ready = 4'hF; z_credit_ret = 4'h0;
    cyc(); cyc();
    reset = 1'b0;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_run++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_run++; if (pkt_count !== 16'h0) begin n_fail++; $display("FAIL reset_pkt_count: got %h expected 0000", pkt_count); end
    n_run++; if (out_data !== 11'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 000", out_data); end
    n_run++; if (cred_err !== 1'b0) begin n_fail++; $display("FAIL reset_cred_err: got %b expected 0", cred_err); end
  endtask

  task automatic test_basic();
    out_ready = 4'hF;
    in_valid = 1'b1; in_data = 11'h002;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_accept_ready: got %b expected 1", in_ready); end
    cyc();
    in_valid = 1'b0; in_data = 11'h7FD;
    n_run++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL basic_fwd_valid: got %b expected 0000", out_valid); end
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_fwd_busy: got %b expected 1", busy); end
    cyc();
    n_run++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL basic_send_valid: got %b expected 0100", out_valid); end
    n_run++; if (out_data !== 11'h002) begin n_fail++; $display("FAIL basic_send_data: got %h expected 002", out_data); end
    cyc();
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_back_ready: got %b expected 0", in_ready); end
    n_run++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL basic_pkt_count: got %h expected 0001", pkt_count); end
    cyc();
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_return: got %b expected 1", in_ready); end
    n_run++; if (dut.credit_q[2] !== 3'd3) begin n_fail++; $display("FAIL basic_credit2: got %0d expected 3", dut.credit_q[2]); end
  endtask

  task automatic test_credit_stall();
    repeat (4) send_pkt(11'h101);
    n_run++; if (pkt_count !== 16'd5) begin n_fail++; $display("FAIL stall_pkt_count4: got %h expected 0005", pkt_count); end
    in_valid = 1'b1; in_data = 11'h3C5; cyc();
    in_valid = 1'b0; cyc();
    n_run++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL stall_no_valid: got %b expected 0000", out_valid); end
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b expected 1", busy); end
    cyc();
    n_run++; if (out_data !== 11'h3C5) begin n_fail++; $display("FAIL stall_data_stable: got %h expected 3C5", out_data); end
    n_run++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL stall_still_held: got %b expected 0000", out_valid); end
    credit_ret = 4'b0010; cyc();
    credit_ret = 4'b0000;
    n_run++; if (out_valid !== 4'b0010) begin n_fail++; $display("FAIL stall_release_valid: got %b expected 0010", out_valid); end
    cyc();
    n_run++; if (pkt_count !== 16'd6) begin n_fail++; $display("FAIL stall_pkt_count5: got %h expected 0006", pkt_count); end
    cyc();
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_return: got %b expected 1", in_ready); end
  endtask

  task automatic test_credit_parallel();
    credit_ret = 4'b0110; cyc();
    credit_ret = 4'b0000;
    n_run++; if (dut.credit_q[1] !== 3'd1) begin n_fail++; $display("FAIL parallel_credit1: got %0d expected 1", dut.credit_q[1]); end
    n_run++; if (dut.credit_q[2] !== 3'd4) begin n_fail++; $display("FAIL parallel_credit2: got %0d expected 4", dut.credit_q[2]); end
    n_run++; if (cred_err !== 1'b0) begin n_fail++; $display("FAIL parallel_no_err: got %b expected 0", cred_err); end
  endtask

  task automatic test_credit_same_cycle();
    send_pkt(11'h003);
    send_pkt(11'h04B);
    in_valid = 1'b1; in_data = 11'h0A7; cyc();
    in_valid = 1'b0; cyc();
    n_run++; if (out_valid !== 4'b1000) begin n_fail++; $display("FAIL same_valid3: got %b expected 1000", out_valid); end
    credit_ret = 4'b1000; cyc();
    credit_ret = 4'b0000;
    n_run++; if (dut.credit_q[3] !== 3'd2) begin n_fail++; $display("FAIL same_credit3: got %0d expected 2", dut.credit_q[3]); end
    cyc(); cyc();
    n_run++; if (pkt_count !== 16'd9) begin n_fail++; $display("FAIL same_pkt_count: got %h expected 0009", pkt_count); end
    credit_ret = 4'b0001; cyc();
    credit_ret = 4'b0000;
    n_run++; if (cred_err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b expected 1", cred_err); end
    n_run++; if (dut.credit_q[0] !== 3'd4) begin n_fail++; $display("FAIL overflow_credit0: got %0d expected 4", dut.credit_q[0]); end
  endtask

  task automatic test_reset_mid_send();
    out_ready = 4'b1011;
    in_valid = 1'b1; in_data = 11'h00E; cyc();
    in_valid = 1'b0; cyc();
    n_run++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL midsend_valid: got %b expected 0100", out_valid); end
    cyc();
    n_run++; if (pkt_count !== 16'd9) begin n_fail++; $display("FAIL midsend_ignored_ready: got %h expected 0009", pkt_count); end
    reset = 1'b1; cyc();
    reset = 1'b0;
    n_run++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL midsend_reset_valid: got %b expected 0000", out_valid); end
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midsend_reset_ready: got %b expected 1", in_ready); end
    n_run++; if (pkt_count !== 16'h0) begin n_fail++; $display("FAIL midsend_reset_count: got %h expected 0000", pkt_count); end
    n_run++; if (cred_err !== 1'b0) begin n_fail++; $display("FAIL midsend_reset_err: got %b expected 0", cred_err); end
    for (int i = 0; i < 4; i++) begin
      n_run++; if (dut.credit_q[i] !== 3'd4) begin n_fail++; $display("FAIL midsend_reset_credit%0d: got %0d expected 4", i, dut.credit_q[i]); end
    end
    out_ready = 4'hF;
  endtask

  task automatic test_back_to_back();
    logic [10:0] d   [3] = '{11'h010, 11'h121, 11'h233};
    logic [3:0]  exp [3] = '{4'b0001, 4'b0010, 4'b1000};
    z_out_ready = 4'hF;
    z_in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      z_in_data = d[k];
      n_run++; if (z_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", k, z_in_ready); end
      cyc();
      n_run++; if (z_out_valid !== exp[k]) begin n_fail++; $display("FAIL b2b_valid%0d: got %b expected %b", k, z_out_valid, exp[k]); end
      n_run++; if (z_out_data !== d[k]) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", k, z_out_data, d[k]); end
      cyc();
    end
    z_in_valid = 1'b0;
    n_run++; if (z_pkt_count !== 16'd3) begin n_fail++; $display("FAIL b2b_pkt_count: got %h expected 0003", z_pkt_count); end
  endtask

  task automatic test_wrap();
    force dut.pkt_count_d = 16'hFFFF;
    cyc();
    release dut.pkt_count_d;
    n_run++; if (pkt_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected FFFF", pkt_count); end
    in_valid = 1'b1; in_data = 11'h001; cyc();
    in_valid = 1'b0; cyc();
    n_run++; if (out_valid !== 4'b0010) begin n_fail++; $display("FAIL wrap_valid: got %b expected 0010", out_valid); end
    cyc();
    n_run++; if (pkt_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got %h expected 0000", pkt_count); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_stall();
    test_credit_parallel();
    test_credit_same_cycle();
    test_reset_mid_send();
    test_back_to_back();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
